// File: rtl/core_pkg.sv
// Shared widths and operand/ROB-read record types for the rename/operand stage.
// The operand record is what the reservation station consumes; the ROB read record is what the ROB returns.
package core_pkg;

  localparam int NREG  = 32;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam int REG_W = $clog2(NREG);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [XLEN-1:0]  data_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic  ready;
    tag_t  tag;
    data_t data;
  } operand_t;

  typedef struct packed {
    logic  valid;
    data_t data;
  } rob_rd_t;

  function automatic operand_t make_operand(input logic ready, input tag_t tag, input data_t data);
    operand_t w_res;
    w_res.ready = ready;
    w_res.tag   = tag;
    w_res.data  = data;
    return w_res;
  endfunction

endpackage

// File: rtl/arf_bank.sv
// Architectural register file: NREG x XLEN flops, two async read ports, one write port.
// x0 is never written and always reads as zero.
import core_pkg::*;

module arf_bank (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_W-1:0]  i_raddr1,
  input  logic [REG_W-1:0]  i_raddr2,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  // NOTE: the register file must read zero straight out of reset, so every entry
  // is cleared on reset and the array is built from flops rather than a RAM macro.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/register_status_table.sv
// Rename/operand stage: per-register busy bit and newest-producer ROB tag, source resolution
// against ARF / commit bypass / ROB, dispatch renaming and commit retirement.
import core_pkg::*;

module register_status_table (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_W-1:0]  dc_rs1,
  input  logic [REG_W-1:0]  dc_rs2,
  input  logic [REG_W-1:0]  dc_rd,
  input  logic              dc_rd_we,
  input  logic [TAG_W-1:0]  free_entry,
  output logic [TAG_W-1:0]  tag1,
  output logic [TAG_W-1:0]  tag2,
  input  rob_rd_t           rob_data1,
  input  rob_rd_t           rob_data2,
  input  logic              commit_we,
  input  logic [5:0]        commit_dest,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [XLEN-1:0]   commit_data,
  output operand_t          op1,
  output operand_t          op2
);

  logic [NREG-1:0]  r_busy;
  logic [TAG_W-1:0] r_map [NREG];

  logic [REG_W-1:0] w_cdest;
  logic             w_commit_ok;
  logic             w_dispatch;
  logic [XLEN-1:0]  w_arf1;
  logic [XLEN-1:0]  w_arf2;

  assign w_cdest     = commit_dest[REG_W-1:0];
  assign w_commit_ok = commit_we && !commit_dest[5] && (w_cdest != '0);
  assign w_dispatch  = !stall && !flush && dc_rd_we && (dc_rd != '0);

  arf_bank u_arf (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_commit_ok),
    .i_waddr  (w_cdest),
    .i_wdata  (commit_data),
    .i_raddr1 (dc_rs1),
    .i_raddr2 (dc_rs2),
    .o_rdata1 (w_arf1),
    .o_rdata2 (w_arf2)
  );

  // Commit clears busy only when it retires the newest producer; a same-cycle rename
  // is written after it so dispatch wins, and flush drops every in-flight mapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_map[i] <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (w_commit_ok && (r_map[w_cdest] == commit_tag)) begin
        r_busy[w_cdest] <= 1'b0;
      end
      if (w_dispatch) begin
        r_busy[dc_rd] <= 1'b1;
        r_map[dc_rd]  <= free_entry;
      end
    end
  end

  function automatic operand_t resolve(
    input logic [REG_W-1:0] rs,
    input logic             busy,
    input logic [TAG_W-1:0] map,
    input logic [XLEN-1:0]  arf,
    input rob_rd_t          rob,
    input logic             c_we,
    input logic [TAG_W-1:0] c_tag,
    input logic [XLEN-1:0]  c_data
  );
    operand_t w_res;
    if (rs == '0) begin
      w_res = make_operand(1'b1, '0, '0);
    end else if (!busy) begin
      w_res = make_operand(1'b1, '0, arf);
    end else if (c_we && (c_tag == map)) begin
      w_res = make_operand(1'b1, '0, c_data);
    end else if (rob.valid) begin
      w_res = make_operand(1'b1, '0, rob.data);
    end else begin
      w_res = make_operand(1'b0, map, '0);
    end
    return w_res;
  endfunction

  // Sources see the state before this cycle's rename, so rd==rsN needs no special case.
  assign tag1 = r_busy[dc_rs1] ? r_map[dc_rs1] : '0;
  assign tag2 = r_busy[dc_rs2] ? r_map[dc_rs2] : '0;

  assign op1 = resolve(dc_rs1, r_busy[dc_rs1], r_map[dc_rs1], w_arf1, rob_data1,
                       commit_we, commit_tag, commit_data);
  assign op2 = resolve(dc_rs2, r_busy[dc_rs2], r_map[dc_rs2], w_arf2, rob_data2,
                       commit_we, commit_tag, commit_data);

endmodule
